// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte sources
// and runs its Send/Sent four-phase handshake. Optional watchdog: UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4
`ifdef UART_TX_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 2048
`endif
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic                 busy,
    output logic [2:0]           cur_id,
    output logic                 tx_send,
    output logic [7:0]           tx_din,
    input  logic                 tx_sent
`ifdef UART_TX_ARB_TIMEOUT_EN
    , output logic               timeout_err
`endif
);

    typedef enum logic [1:0] {
        sIdle    = 2'd0,
        sSend    = 2'd1,
        sWaitLow = 2'd2
    } state_t;

    state_t               state_r, state_s;
    logic [2:0]           last_r, last_s;
    logic [NUM_REQ-1:0]   ack_s;
    logic                 busy_s;
    logic [2:0]           id_s;
    logic                 send_s;
    logic [7:0]           din_s;
    logic [7:0]           req_pad_s;
    logic [63:0]          data_pad_s;
    logic                 grant_valid_s;
    logic [2:0]           grant_id_s;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [15:0]          tmo_cnt_r, tmo_cnt_s;
    logic                 tmo_err_s;
`endif

    // Requester index k steps after the last-served one, modulo NUM_REQ.
    function automatic logic [2:0] rr_index(input logic [2:0] base, input int k);
        return 3'((int'(base) + 32'sd1 + k) % NUM_REQ);
    endfunction

    assign req_pad_s  = 8'(req_valid);
    assign data_pad_s = 64'(req_data);

    // Round-robin winner search; scanning downward lets the nearest request win.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 3'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            grant_valid_s = grant_valid_s | req_pad_s[rr_index(last_r, k)];
            grant_id_s    = req_pad_s[rr_index(last_r, k)] ? rr_index(last_r, k) : grant_id_s;
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s = state_r;
        last_s  = last_r;
        ack_s   = {NUM_REQ{1'b0}};
        busy_s  = busy;
        id_s    = cur_id;
        send_s  = tx_send;
        din_s   = tx_din;
`ifdef UART_TX_ARB_TIMEOUT_EN
        tmo_cnt_s = tmo_cnt_r;
        tmo_err_s = timeout_err;
`endif
        case (state_r)
            sIdle: begin
                if (grant_valid_s) begin
                    din_s   = data_pad_s[{grant_id_s, 3'b000} +: 8];
                    id_s    = grant_id_s;
                    ack_s   = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_s;
                    send_s  = 1'b1;
                    busy_s  = 1'b1;
                    state_s = sSend;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    tmo_cnt_s = 16'd0;
`endif
                end else begin
                    state_s = sIdle;
                end
            end
            sSend: begin
                if (tx_sent) begin
                    send_s  = 1'b0;
                    state_s = sWaitLow;
`ifdef UART_TX_ARB_TIMEOUT_EN
                // Counter starts at 0, so this compare fires in the TIMEOUT_CYCLES-th sSend cycle.
                end else if (tmo_cnt_r == 16'(TIMEOUT_CYCLES - 1)) begin
                    send_s    = 1'b0;
                    tmo_err_s = 1'b1;
                    state_s   = sWaitLow;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + 16'd1;
                end
`else
                end else begin
                    state_s = sSend;
                end
`endif
            end
            sWaitLow: begin
                if (!tx_sent) begin
                    last_s  = cur_id;
                    busy_s  = 1'b0;
                    state_s = sIdle;
                end else begin
                    state_s = sWaitLow;
                end
            end
            default: begin
                send_s  = 1'b0;
                busy_s  = 1'b0;
                state_s = sIdle;
            end
        endcase
    end

    // State, pointer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_r <= sIdle;
            last_r  <= 3'(NUM_REQ - 1);
            req_ack <= {NUM_REQ{1'b0}};
            busy    <= 1'b0;
            cur_id  <= 3'd0;
            tx_send <= 1'b0;
            tx_din  <= 8'h00;
`ifdef UART_TX_ARB_TIMEOUT_EN
            tmo_cnt_r   <= 16'd0;
            timeout_err <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            last_r  <= last_s;
            req_ack <= ack_s;
            busy    <= busy_s;
            cur_id  <= id_s;
            tx_send <= send_s;
            tx_din  <= din_s;
`ifdef UART_TX_ARB_TIMEOUT_EN
            tmo_cnt_r   <= tmo_cnt_s;
            timeout_err <= tmo_err_s;
`endif
        end
    end

endmodule
